// File: rtl/fofb_readout_sequencer_pkg.sv
// Shared types and field positions for the FOFB readout sequencer.
package fofb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_PARK  = 2'd2
  } fofb_state_e;

  localparam int STATUS_ENABLE_BIT  = 31;
  localparam int STATUS_BUSY_BIT    = 30;
  localparam int STATUS_TIMEOUT_BIT = 29;
  localparam int STATUS_OVERRUN_LSB = 21;
  localparam int OVERRUN_WIDTH      = 8;

  localparam int GPIO_COUNT_LSB  = 0;
  localparam int GPIO_ENABLE_BIT = 31;

endpackage

// File: rtl/fofb_readout_sequencer_if.sv
// Indexed BPM data stream from the sequencer to the correction DSP.
// dspValid is a one-cycle strobe qualifying dspIndex/dspLast/dspX/Y/S; the DSP has no backpressure.
interface fofb_readout_sequencer_if #(
  parameter int INDEX_WIDTH = 9
);
  logic                   dspValid;
  logic [INDEX_WIDTH-1:0] dspIndex;
  logic                   dspLast;
  logic [31:0]            dspX;
  logic [31:0]            dspY;
  logic [31:0]            dspS;

  modport master (output dspValid, dspIndex, dspLast, dspX, dspY, dspS);
  modport slave  (input  dspValid, dspIndex, dspLast, dspX, dspY, dspS);
endinterface

// File: rtl/fofb_readout_sequencer_hold_timer.sv
// Per-address hold counter: counts HOLD_CYCLES-1 down to 0, flags the capture slot and expiry.
module fofb_hold_timer #(
  parameter int HOLD_CYCLES  = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_run,
  output logic o_capture,
  output logic o_expire
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CAPTURE = CW'(HOLD_CYCLES - 1 - READ_LATENCY);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= RELOAD;
    end else if (i_load) begin
      r_cnt <= RELOAD;
    end else if (i_run) begin
      r_cnt <= (r_cnt == '0) ? RELOAD : r_cnt - CW'(1);
    end
  end

  assign o_capture = i_run && (r_cnt == CAPTURE);
  assign o_expire  = i_run && (r_cnt == '0);

endmodule

// File: rtl/fofb_readout_sequencer.sv
// Sweeps the link-gathering readout address once per FA cycle and streams captured X/Y/S to the DSP.
module fofb_readout_sequencer
  import fofb_pkg::*;
#(
  parameter int FOFB_INDEX_WIDTH = 9,
  parameter int READ_LATENCY     = 2,
  parameter int HOLD_CYCLES      = 4
) (
  input  logic                        sysClk,
  input  logic                        sysResetN,
  input  logic                        csrStrobe,
  input  logic [31:0]                 GPIO_OUT,
  output logic [31:0]                 status,
  input  logic                        FAstrobe,
  input  logic                        readoutValid,
  input  logic                        readTimeout,
  output logic [FOFB_INDEX_WIDTH-1:0] readoutAddress,
  input  logic [31:0]                 readoutX,
  input  logic [31:0]                 readoutY,
  input  logic [31:0]                 readoutS,
  fofb_readout_sequencer_if.master    dsp,
  output logic                        sweepDone,
  output logic                        overrunStrobe,
  output fofb_state_e                 o_dbg_state
);

  localparam int W = FOFB_INDEX_WIDTH;
  // Two top addresses are reserved as park slots, so never count them as BPMs.
  localparam logic [W:0] MAX_COUNT = (W+1)'((1 << W) - 2);

  fofb_state_e              r_state;
  logic                     r_enable;
  logic                     r_last_timeout;
  logic                     r_level_d;
  logic                     r_abort;
  logic [W:0]               r_bpm_count;
  logic [W-1:0]             r_addr;
  logic [W-1:0]             r_last_idx;
  logic [OVERRUN_WIDTH-1:0] r_overrun_cnt;
  logic                     r_dsp_valid;
  logic                     r_dsp_last;
  logic [W-1:0]             r_dsp_index;
  logic [31:0]              r_dsp_x;
  logic [31:0]              r_dsp_y;
  logic [31:0]              r_dsp_s;
  logic                     r_sweep_done;
  logic                     r_overrun;

  logic [W:0] w_cfg_raw;
  logic [W:0] w_cfg_count;
  logic       w_level;
  logic       w_trigger;
  logic       w_start;
  logic       w_sweeping;
  logic       w_capture;
  logic       w_expire;
  logic       w_unused_gpio;

  assign w_cfg_raw     = GPIO_OUT[GPIO_COUNT_LSB +: W+1];
  assign w_cfg_count   = (w_cfg_raw > MAX_COUNT) ? MAX_COUNT : w_cfg_raw;
  assign w_unused_gpio = ^GPIO_OUT[GPIO_ENABLE_BIT-1:GPIO_COUNT_LSB+W+1];

  // A coincident FAstrobe suppresses the start: the new FA cycle supersedes this readout.
  assign w_level    = readoutValid | readTimeout;
  assign w_trigger  = w_level && !r_level_d && r_enable && (r_state == ST_IDLE) && !FAstrobe;
  assign w_start    = w_trigger && (r_bpm_count != '0);
  assign w_sweeping = (r_state == ST_SWEEP);

  fofb_hold_timer #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .READ_LATENCY (READ_LATENCY)
  ) u_hold_timer (
    .i_clk     (sysClk),
    .i_rst_n   (sysResetN),
    .i_load    (w_start),
    .i_run     (w_sweeping),
    .o_capture (w_capture),
    .o_expire  (w_expire)
  );

  always_ff @(posedge sysClk or negedge sysResetN) begin
    if (!sysResetN) begin
      r_state        <= ST_IDLE;
      r_enable       <= 1'b0;
      r_last_timeout <= 1'b0;
      r_level_d      <= 1'b0;
      r_abort        <= 1'b0;
      r_bpm_count    <= '0;
      r_addr         <= '1;
      r_last_idx     <= '0;
      r_overrun_cnt  <= '0;
      r_dsp_valid    <= 1'b0;
      r_dsp_last     <= 1'b0;
      r_dsp_index    <= '0;
      r_dsp_x        <= '0;
      r_dsp_y        <= '0;
      r_dsp_s        <= '0;
      r_sweep_done   <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_dsp_valid  <= 1'b0;
      r_dsp_last   <= 1'b0;
      r_sweep_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_level_d    <= w_level;

      if (csrStrobe) begin
        r_bpm_count <= w_cfg_count;
        r_enable    <= GPIO_OUT[GPIO_ENABLE_BIT];
      end

      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_last_timeout <= readTimeout & ~readoutValid;
            if (r_bpm_count == '0) begin
              r_sweep_done <= 1'b1;
            end else begin
              r_state    <= ST_SWEEP;
              r_addr     <= '0;
              r_last_idx <= W'(r_bpm_count - (W+1)'(1));
              r_abort    <= 1'b0;
            end
          end
        end

        ST_SWEEP: begin
          if (FAstrobe) begin
            r_overrun <= 1'b1;
            if (r_overrun_cnt != '1) r_overrun_cnt <= r_overrun_cnt + 8'd1;
            r_abort <= 1'b1;
            r_addr  <= {{(W-1){1'b1}}, ~r_addr[0]};
            r_state <= ST_PARK;
          end else begin
            if (w_capture) begin
              r_dsp_x     <= readoutX;
              r_dsp_y     <= readoutY;
              r_dsp_s     <= readoutS;
              r_dsp_index <= r_addr;
              r_dsp_valid <= 1'b1;
              r_dsp_last  <= (r_addr == r_last_idx);
            end
            // The park slot's LSB is the complement of the last index so its save DPRAM commits.
            if (w_expire) begin
              if (r_addr != r_last_idx) begin
                r_addr <= r_addr + W'(1);
              end else begin
                r_addr  <= {{(W-1){1'b1}}, ~r_addr[0]};
                r_state <= ST_PARK;
              end
            end
          end
        end

        ST_PARK: begin
          r_sweep_done <= !r_abort;
          r_state      <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    status                                           = '0;
    status[STATUS_ENABLE_BIT]                        = r_enable;
    status[STATUS_BUSY_BIT]                          = (r_state != ST_IDLE);
    status[STATUS_TIMEOUT_BIT]                       = r_last_timeout;
    status[STATUS_OVERRUN_LSB +: OVERRUN_WIDTH]      = r_overrun_cnt;
    status[W:0]                                      = r_bpm_count;
  end

  assign readoutAddress = r_addr;
  assign sweepDone      = r_sweep_done;
  assign overrunStrobe  = r_overrun;
  assign o_dbg_state    = r_state;
  assign dsp.dspValid   = r_dsp_valid;
  assign dsp.dspIndex   = r_dsp_index;
  assign dsp.dspLast    = r_dsp_last;
  assign dsp.dspX       = r_dsp_x;
  assign dsp.dspY       = r_dsp_y;
  assign dsp.dspS       = r_dsp_s;

endmodule

// File: tb/tb_fofb_readout_sequencer.sv
// Bench for fofb_readout_sequencer: random sweeps against a cycle-schedule model of the readout rules.
`timescale 1ns/1ps
module tb_fofb_readout_sequencer;
  import fofb_pkg::*;

  localparam int W = 9;
  localparam int L = 2;
  localparam int H = 4;
  localparam int MAX_BPM = (1 << W) - 2;
  localparam int ADDR_TOP = (1 << W) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              csr_strobe = 1'b0;
  logic [31:0]       gpio_out = '0;
  logic [31:0]       status;
  logic              fa_strobe = 1'b0;
  logic              readout_valid = 1'b0;
  logic              read_timeout = 1'b0;
  logic [W-1:0]      readout_address;
  logic [31:0]       readout_x;
  logic [31:0]       readout_y;
  logic [31:0]       readout_s;
  logic              sweep_done;
  logic              overrun_strobe;
  fofb_state_e       dbg_state;

  fofb_readout_sequencer_if #(.INDEX_WIDTH(W)) dsp_if();

  fofb_readout_sequencer #(
    .FOFB_INDEX_WIDTH (W),
    .READ_LATENCY     (L),
    .HOLD_CYCLES      (H)
  ) dut (
    .sysClk         (clk),
    .sysResetN      (rst_n),
    .csrStrobe      (csr_strobe),
    .GPIO_OUT       (gpio_out),
    .status         (status),
    .FAstrobe       (fa_strobe),
    .readoutValid   (readout_valid),
    .readTimeout    (read_timeout),
    .readoutAddress (readout_address),
    .readoutX       (readout_x),
    .readoutY       (readout_y),
    .readoutS       (readout_s),
    .dsp            (dsp_if),
    .sweepDone      (sweep_done),
    .overrunStrobe  (overrun_strobe),
    .o_dbg_state    (dbg_state)
  );

  // Upstream DPRAM + mux: data follows the address after L clocks.
  logic [31:0]  mem_x [0:ADDR_TOP];
  logic [31:0]  mem_y [0:ADDR_TOP];
  logic [31:0]  mem_s [0:ADDR_TOP];
  logic [W-1:0] rd_a1;
  always @(posedge clk) begin
    rd_a1     <= readout_address;
    readout_x <= mem_x[rd_a1];
    readout_y <= mem_y[rd_a1];
    readout_s <= mem_s[rd_a1];
  end

  // scoreboard and reference state
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  int           bpm_model = 0;
  bit           en_model = 1'b0;
  bit           to_model = 1'b0;
  int           ovr_model = 0;
  int           addr_model = ADDR_TOP;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int park_of(input int idx);
    return (idx % 2 == 1) ? ADDR_TOP - 1 : ADDR_TOP;
  endfunction

  task automatic fill_mem(input bit ramp);
    for (int a = 0; a <= ADDR_TOP; a++) begin
      mem_x[a] = ramp ? 32'(a * 16 + 1) : $urandom;
      mem_y[a] = ramp ? 32'(a * 16 + 2) : $urandom;
      mem_s[a] = ramp ? 32'(a * 16 + 3) : $urandom;
    end
  endtask

  task automatic cfg(input bit en, input int count);
    @(negedge clk);
    gpio_out     = 32'(count);
    gpio_out[31] = en;
    csr_strobe   = 1'b1;
    @(negedge clk);
    csr_strobe = 1'b0;
    en_model   = en;
    bpm_model  = (count > MAX_BPM) ? MAX_BPM : count;
  endtask

  task automatic check_status();
    chk("status_enable",  32'(status[31]), 32'(en_model));
    chk("status_timeout", 32'(status[29]), 32'(to_model));
    chk("status_overrun", 32'(status[28:21]), 32'(ovr_model));
    chk("status_bpm",     32'(status[W:0]), 32'(bpm_model));
  endtask

  // Trigger one readout and check every cycle against the schedule derived from n / abort cycle.
  // Cycle j=1 is the first cycle after the trigger edge; abort_at=a puts FAstrobe in cycle a.
  task automatic run_sweep(input int n, input int abort_at, input bit use_to, input int clr_en_at);
    int           hold_end, busy_end, m, exp_addr, start_addr;
    bit           exp_valid;
    logic [W-1:0] prev_addr, cur_addr, exp_idx;
    exp_q.delete();
    for (int i = 0; i < n; i++)
      if (abort_at == 0 || H * i + L + 2 <= abort_at) exp_q.push_back(W'(i));
    hold_end   = (abort_at != 0) ? abort_at : n * H;
    busy_end   = (n == 0) ? 0 : hold_end + 1;
    m          = hold_end + 3;
    start_addr = addr_model;
    @(negedge clk);
    if (use_to) read_timeout = 1'b1;
    else        readout_valid = 1'b1;
    prev_addr = readout_address;
    for (int j = 1; j <= m; j++) begin
      @(negedge clk);
      fa_strobe  = 1'b0;
      csr_strobe = 1'b0;
      cur_addr   = readout_address;
      if (n == 0)             exp_addr = start_addr;
      else if (j <= hold_end) exp_addr = (j - 1) / H;
      else                    exp_addr = park_of((hold_end - 1) / H);
      chk("addr", 32'(cur_addr), 32'(exp_addr));
      if (cur_addr != prev_addr && int'(prev_addr) < n)
        chk("lsb_toggle", 32'(cur_addr[0]), 32'(!prev_addr[0]));
      exp_valid = (n != 0) && (j <= hold_end) && (j >= L + 2) && ((j - L - 2) % H == 0);
      chk("dsp_valid", 32'(dsp_if.dspValid), 32'(exp_valid));
      if (dsp_if.dspValid) begin
        chk("dsp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_idx = exp_q.pop_front();
          chk("dsp_index", 32'(dsp_if.dspIndex), 32'(exp_idx));
          chk("dsp_x", dsp_if.dspX, mem_x[exp_idx]);
          chk("dsp_y", dsp_if.dspY, mem_y[exp_idx]);
          chk("dsp_s", dsp_if.dspS, mem_s[exp_idx]);
          chk("dsp_last", 32'(dsp_if.dspLast), 32'(int'(exp_idx) == n - 1));
        end
      end else begin
        chk("dsp_last_idle", 32'(dsp_if.dspLast), 32'd0);
      end
      chk("sweep_done", 32'(sweep_done),
          32'((n == 0) ? (j == 1) : (abort_at == 0 && j == hold_end + 2)));
      chk("overrun_strobe", 32'(overrun_strobe), 32'(abort_at != 0 && j == hold_end + 1));
      chk("busy", 32'(status[30]), 32'(j <= busy_end));
      prev_addr = cur_addr;
      fa_strobe = (abort_at != 0 && j == abort_at);
      if (clr_en_at != 0 && j == clr_en_at) begin
        gpio_out   = 32'(bpm_model);
        csr_strobe = 1'b1;
        en_model   = 1'b0;
      end
    end
    chk("dsp_q_drained", 32'(exp_q.size()), 32'd0);
    if (n != 0) addr_model = park_of((hold_end - 1) / H);
    if (abort_at != 0 && ovr_model < 255) ovr_model++;
    to_model = use_to;
    check_status();
    @(negedge clk);
    readout_valid = 1'b0;
    read_timeout  = 1'b0;
    @(negedge clk);
  endtask

  // Nothing may happen: address parked, no strobes, not busy.
  task automatic expect_quiet(input int cycles);
    for (int j = 0; j < cycles; j++) begin
      @(negedge clk);
      fa_strobe = 1'b0;
      chk("quiet_addr", 32'(readout_address), 32'(addr_model));
      chk("quiet_valid", 32'(dsp_if.dspValid), 32'd0);
      chk("quiet_done", 32'(sweep_done), 32'd0);
      chk("quiet_overrun", 32'(overrun_strobe), 32'd0);
      chk("quiet_busy", 32'(status[30]), 32'd0);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_addr", 32'(readout_address), 32'(ADDR_TOP));
    chk("rst_status", status, 32'd0);
    chk("rst_valid", 32'(dsp_if.dspValid), 32'd0);
    chk("rst_last", 32'(dsp_if.dspLast), 32'd0);
    chk("rst_index", 32'(dsp_if.dspIndex), 32'd0);
    chk("rst_x", dsp_if.dspX, 32'd0);
    chk("rst_y", dsp_if.dspY, 32'd0);
    chk("rst_s", dsp_if.dspS, 32'd0);
    chk("rst_done", 32'(sweep_done), 32'd0);
    chk("rst_overrun", 32'(overrun_strobe), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rn, ra;
    fill_mem(1'b0);
    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);

    // basic four-BPM sweep, last index odd -> park 510
    cfg(1'b1, 4);
    run_sweep(4, 0, 1'b0, 0);

    // ramp data, last index even -> park 511
    fill_mem(1'b1);
    cfg(1'b1, 3);
    run_sweep(3, 0, 1'b0, 0);

    // timeout-triggered sweep, then a normal one clears the flag
    fill_mem(1'b0);
    cfg(1'b1, 5);
    run_sweep(5, 0, 1'b1, 0);
    run_sweep(5, 0, 1'b0, 0);

    // FAstrobe in cycle 6 of an eight-BPM sweep
    cfg(1'b1, 8);
    run_sweep(8, 6, 1'b0, 0);

    // enable dropped mid-sweep: sweep completes, next trigger ignored
    cfg(1'b1, 3);
    run_sweep(3, 0, 1'b0, 5);
    @(negedge clk);
    readout_valid = 1'b1;
    expect_quiet(6);
    readout_valid = 1'b0;
    @(negedge clk);

    // empty sweep and count clamping
    cfg(1'b1, 0);
    run_sweep(0, 0, 1'b0, 0);
    cfg(1'b1, 1023);
    chk("clamp_bpm", 32'(status[W:0]), 32'(bpm_model));

    // FAstrobe coincident with trigger wins
    cfg(1'b1, 2);
    @(negedge clk);
    readout_valid = 1'b1;
    fa_strobe     = 1'b1;
    expect_quiet(5);
    readout_valid = 1'b0;
    @(negedge clk);
    check_status();

    // randomized sweeps with optional aborts
    for (int k = 0; k < 10; k++) begin
      rn = $urandom_range(1, 6);
      ra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, rn * H) : 0;
      fill_mem(1'b0);
      cfg(1'b1, rn);
      run_sweep(rn, ra, 1'($urandom_range(0, 1)), 0);
    end

    // overrun counter saturates at 255
    cfg(1'b1, 1);
    repeat (256) run_sweep(1, 1, 1'b0, 0);

    // reset in the middle of a sweep
    fill_mem(1'b0);
    cfg(1'b1, 8);
    @(negedge clk);
    readout_valid = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    en_model   = 1'b0;
    bpm_model  = 0;
    to_model   = 1'b0;
    ovr_model  = 0;
    addr_model = ADDR_TOP;
    readout_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_status();
    cfg(1'b1, 5);
    run_sweep(5, 0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
